// File: rtl/jk_counter_pkg.sv
// Shared constants and JK excitation helper for the JK-cell counter.
package jk_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [1:0] jk_excite(input logic q_bit, input logic next_bit);
        logic t;
        t = q_bit ^ next_bit;
        return {t, t};
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Positive-edge JK flip-flop, async active-high reset to 0.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00: q <= q;
                2'b10: q <= 1'b1;
                2'b01: q <= 1'b0;
                2'b11: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter built from JK cells, with sticky wrap flag.
// Optional parallel load enabled by defining JK_COUNTER_LOAD_EN.
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
`ifdef JK_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_sync_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load_act;
    logic             wrap_set;

`ifdef JK_COUNTER_LOAD_EN
    assign load_act = load;
`else
    assign load_act = 1'b0;
`endif

    assign tc = en & (((up == DIR_UP) & (q == MAX_Q)) |
                      ((up == DIR_DOWN) & (q == '0)));

    assign wrap_set = tc & ~load_act;

    always_comb begin
        nxt = q;
`ifdef JK_COUNTER_LOAD_EN
        if (load) begin
            nxt = ({1'b0, d} < MOD_W) ? d : MAX_Q;
        end else
`endif
        if (en) begin
            if (up == DIR_UP) begin
                nxt = (q >= MAX_Q) ? '0 : q + 1'b1;
            end else begin
                // Out-of-range states (only reachable via load) recover to the top.
                nxt = (q == '0 || {1'b0, q} >= MOD_W) ? MAX_Q : q - 1'b1;
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_excite(q[i], nxt[i]);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff u_ff (
            .clk  (clk),
            .reset(reset),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrapped <= 1'b0;
        end else if (wrap_set) begin
            wrapped <= 1'b1;
        end else if (clr_flag) begin
            wrapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10).
module tb_jk_sync_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       clr_flag;
    logic [3:0] q;
    logic       tc;
    logic       wrapped;
`ifdef JK_COUNTER_LOAD_EN
    logic       load;
    logic [3:0] d;
`endif

    int n_chk;
    int n_pass;

    jk_sync_counter #(
        .WIDTH  (4),
        .MODULUS(10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
`ifdef JK_COUNTER_LOAD_EN
        .load    (load),
        .d       (d),
`endif
        .clr_flag(clr_flag),
        .q       (q),
        .tc      (tc),
        .wrapped (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int eq, input int etc, input int ew);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".tc"}, 32'(tc), 32'(etc));
        chk({tag, ".wrapped"}, 32'(wrapped), 32'(ew));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        en = 1'b0;
        up = 1'b1;
        clr_flag = 1'b0;
`ifdef JK_COUNTER_LOAD_EN
        load = 1'b0;
        d = 4'd0;
`endif
        #1;
        chk_st("reset", 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        en = 1'b1;
        up = 1'b1;
        #1;
        chk_st("up0", 0, 0, 0);

        for (int i = 1; i <= 12; i++) begin
            step();
            chk_st($sformatf("up%0d", i), i % 10, (i % 10 == 9) ? 1 : 0, (i >= 10) ? 1 : 0);
        end

        en = 1'b0;
        clr_flag = 1'b1;
        step();
        chk_st("clr_a", 2, 0, 0);
        clr_flag = 1'b0;

        en = 1'b1;
        up = 1'b0;
        #1;
        chk_st("dn_start", 2, 0, 0);
        step();
        chk_st("dn1", 1, 0, 0);
        step();
        chk_st("dn0", 0, 1, 0);
        step();
        chk_st("dn9", 9, 0, 1);
        step();
        chk_st("dn8", 8, 0, 1);
        step();
        chk_st("dn7", 7, 0, 1);
        step();
        chk_st("dn6", 6, 0, 1);

        en = 1'b0;
        #1;
        chk_st("hold0", 6, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_st($sformatf("hold%0d", i), 6, 0, 1);
        end

        clr_flag = 1'b1;
        step();
        chk_st("clr_b", 6, 0, 0);
        clr_flag = 1'b0;
        en = 1'b1;
        up = 1'b1;
        step();
        chk_st("cu7", 7, 0, 0);
        step();
        chk_st("cu8", 8, 0, 0);
        step();
        chk_st("cu9", 9, 1, 0);
        clr_flag = 1'b1;
        step();
        chk_st("set_wins", 0, 0, 1);
        step();
        chk_st("clr_c", 1, 0, 0);
        clr_flag = 1'b0;

`ifdef JK_COUNTER_LOAD_EN
        en = 1'b0;
        load = 1'b1;
        d = 4'd13;
        step();
        chk_st("ld_clamp", 9, 0, 0);
        en = 1'b1;
        up = 1'b1;
        d = 4'd7;
        #1;
        chk("ld_tc_pre", 32'(tc), 32'd1);
        step();
        chk_st("ld_noct", 7, 0, 0);
        load = 1'b0;
        step();
        chk_st("ld8", 8, 0, 0);
        step();
        chk_st("ld9", 9, 1, 0);
        step();
        chk_st("ld0", 0, 0, 1);
        en = 1'b0;
        load = 1'b1;
        d = 4'd1;
        clr_flag = 1'b1;
        step();
        chk_st("ld1", 1, 0, 0);
        load = 1'b0;
        clr_flag = 1'b0;
`endif

        en = 1'b1;
        up = 1'b0;
        step();
        chk_st("r0", 0, 1, 0);
        step();
        chk_st("r9", 9, 0, 1);
        step();
        step();
        step();
        step();
        chk_st("r5", 5, 0, 1);
        en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_st("async_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1;
        up = 1'b1;
        step();
        chk_st("post_rst", 1, 0, 0);
        step();
        chk_st("dir_a", 2, 0, 0);
        up = 1'b0;
        step();
        chk_st("dir_b", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
# jk_sync_counter

Synchronous modulo-N up/down counter built from edge-triggered JK flip-flop cells. It is the stage directly downstream of the JK flip-flop work: each count bit is one JK cell, and the J/K inputs are driven by next-state excitation logic. Its outputs `q`, `tc` and `wrapped` feed the lab display and decoder stages.

## Interface
Parameters:
- `WIDTH`, 4: count width in bits.
- `MODULUS`, 10: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; elaboration fails outside it.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = up, 0 = down.
- `load` input 1: parallel load strobe. Present only with `JK_COUNTER_LOAD_EN`.
- `d` input WIDTH: parallel load value. Present only with `JK_COUNTER_LOAD_EN`.
- `clr_flag` input 1: clears the `wrapped` flag.
- `q` output WIDTH: current count.
- `tc` output 1: terminal count, combinational.
- `wrapped` output 1: sticky wrap flag, registered.

## Operation
- Reset (async, `reset`=1): `q`=0 and `wrapped`=0 immediately. `tc`=0 whenever `en`=0.
- Per-edge priority: `reset` > `load` > count (`en`=1) > hold.
- Count up: if `q` ≥ MODULUS-1, next=0; else next=`q`+1.
- Count down: if `q`=0 or `q` ≥ MODULUS, next=MODULUS-1; else next=`q`-1.
- Load: next=`d` if `d` < MODULUS; otherwise next=MODULUS-1 (clamped). Load never sets `wrapped`.
- Per-bit excitation: toggle t_i = `q[i]` XOR next[i], and J_i=K_i=t_i. No JK cell is ever driven to set and reset in the same cycle.
- `tc` = `en` & ((`up` & `q`==MODULUS-1) | (!`up` & `q`==0)).
- `wrapped`: set on any edge where a count wraps (the same condition as `tc`, with `load` inactive). It is cleared by `clr_flag`.
- If set and clear happen on the same edge, set wins.
- `wrapped` stays 1 until `clr_flag` or `reset`.
- Direction change while counting takes effect on the next edge; there are no dead cycles.

## Timing
- `q` and `wrapped` have 1-cycle latency from the inputs sampled at a rising edge.
- `tc` is combinational from `q`, `en` and `up`, valid in the same cycle. It is high in the cycle before the wrap edge.
- Reset asserted mid-count forces `q`=0 without waiting for a clock edge.
- On deassertion, the first count occurs on the first rising edge with `reset`=0 and `en`=1.
- Inputs are synchronous to `clk`. No handshake exists; each edge consumes the inputs.

## Configuration
- `JK_COUNTER_LOAD_EN` defined: the `load` and `d` ports exist, and the load path has priority over counting.
- `JK_COUNTER_LOAD_EN` undefined: the `load` and `d` ports are absent and the load path is removed. The reachable state set is then 0..MODULUS-1 only.

## Structure
- Shared package `jk_counter_pkg`:
  - direction constants `DIR_UP`=1 and `DIR_DOWN`=0;
  - function `jk_excite(q_bit, next_bit)`, which returns the {J,K} pair.
- Sub-module `jk_ff`:
  - positive-edge JK flip-flop with async active-high reset to 0;
  - J/K behaviour: 00 hold, 10 set, 01 clear, 11 toggle.
  - Instantiated WIDTH times.
- The `wrapped` flag lives in the top module as plain registered logic.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
- Reset, then `en`=1, `up`=1 for 12 edges:
  - `q` = 1,2,…,9,0,1,2;
  - `tc`=1 only while `q`=9;
  - `wrapped` goes 1 after the 10th edge.
- From `q`=0, `en`=1, `up`=0: `q` = 9, 8, 7; `tc`=1 in the cycle `q`=0; `wrapped`=1 after the first edge.
- `en`=0 for 5 edges at `q`=6: `q` holds 6 and `tc`=0.
- Load (macro defined):
  - `load`=1, `d`=7, then count up: `q` = 7, 8, 9, 0, and `wrapped` stays 0 through the load.
  - `load`=1 with `d`=13 gives `q`=9.
  - `load`=1 together with `en`=1 loads and does not count.
- Assert `reset` asynchronously mid-cycle at `q`=5 with `wrapped`=1: `q`=0 and `wrapped`=0 before the next edge.
- `clr_flag`=1 on the same edge as the 9→0 wrap: `wrapped` stays 1. `clr_flag`=1 on a following non-wrap edge: `wrapped`=0.
